// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan driver: segment bit order,
// blank codes and the 16-entry active-low glyph table.
package seven_seg_pkg;

   // Segment bit order on seg[6:0]: {g,f,e,d,c,b,a}; all segments active-low.
   typedef struct packed {
      logic g;
      logic f;
      logic e;
      logic d;
      logic c;
      logic b;
      logic a;
   } seg_t;

   localparam logic [6:0] SEG_BLANK    = 7'h7F;
   localparam logic [3:0] NIBBLE_BLANK = 4'hF;
   localparam logic [7:0] AN_OFF       = 8'hFF;

   // Glyphs for nibble values 0..F; entry 15 is the blank code, not a hex F.
   localparam logic [15:0][6:0] GLYPH_TABLE = {
      SEG_BLANK, // F : blank
      7'h06,     // E
      7'h21,     // d
      7'h46,     // C
      7'h03,     // b
      7'h08,     // A
      7'h10,     // 9
      7'h00,     // 8
      7'h78,     // 7
      7'h02,     // 6
      7'h12,     // 5
      7'h19,     // 4
      7'h30,     // 3
      7'h24,     // 2
      7'h79,     // 1
      7'h40      // 0
   };

   // Look up the active-low glyph for one nibble.
   function automatic seg_t glyph_of(input logic [3:0] nibble);
      return seg_t'(GLYPH_TABLE[nibble]);
   endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational nibble -> active-low seven-segment glyph decoder.
module seven_seg_decoder
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   seg_t glyph_s;

   // Table lookup of the glyph for the selected nibble.
   always_comb begin
      glyph_s = glyph_of(nibble);
      seg     = glyph_s;
   end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// A prescaler divides each digit slot into SCAN_DIV cycles, the first
// BLANK_CYCLES of which keep every anode off to avoid ghosting. The digit and
// dot inputs are captured once per frame (on the last cycle of slot 7) so a
// frame is never torn.
// Optional feature macro: BRIGHTNESS_EN adds a 4-bit brightness input that
// shortens the lit part of each slot to (b+1)/16 of the on-window.
module seven_segment_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 100_000,
   parameter int unsigned BLANK_CYCLES = 1_000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] digit,
   input  logic [7:0]  en_dot,
`ifdef BRIGHTNESS_EN
   input  logic [3:0]  brightness,
`endif
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int unsigned      CNT_W    = $clog2(SCAN_DIV);
   localparam int unsigned      WIN_LEN  = SCAN_DIV - BLANK_CYCLES;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [2:0]       idx_r;
   logic [31:0]      shadow_digit_r;
   logic [7:0]       shadow_dot_r;
   logic [3:0]       bright_s;

   logic             slot_end_s;
   logic             frame_end_s;
   logic [31:0]      cnt_ext_s;
   logic [31:0]      on_len_s;
   logic             on_s;
   logic [3:0]       nibble_s;
   logic [6:0]       glyph_s;
   logic [7:0]       an_s;
   logic [6:0]       seg_s;
   logic             dp_s;

   assign slot_end_s  = (cnt_r == CNT_LAST);
   assign frame_end_s = slot_end_s && (idx_r == 3'd7);

   // Prescaler: cycle position inside the current digit slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (slot_end_s) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   // Digit index: advances once per slot and wraps 7 -> 0 by overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_r <= 3'd0;
      end else if (slot_end_s) begin
         idx_r <= idx_r + 3'd1;
      end else begin
         idx_r <= idx_r;
      end
   end

`ifdef BRIGHTNESS_EN
   logic [3:0] shadow_bright_r;

   // Frame snapshot of the display word, dots and brightness.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_digit_r  <= 32'hFFFF_FFFF;
         shadow_dot_r    <= 8'h00;
         shadow_bright_r <= 4'hF;
      end else if (frame_end_s) begin
         shadow_digit_r  <= digit;
         shadow_dot_r    <= en_dot;
         shadow_bright_r <= brightness;
      end else begin
         shadow_digit_r  <= shadow_digit_r;
         shadow_dot_r    <= shadow_dot_r;
         shadow_bright_r <= shadow_bright_r;
      end
   end

   assign bright_s = shadow_bright_r;
`else
   // Frame snapshot of the display word and dots.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_digit_r <= 32'hFFFF_FFFF;
         shadow_dot_r   <= 8'h00;
      end else if (frame_end_s) begin
         shadow_digit_r <= digit;
         shadow_dot_r   <= en_dot;
      end else begin
         shadow_digit_r <= shadow_digit_r;
         shadow_dot_r   <= shadow_dot_r;
      end
   end

   // Without the brightness feature the full on-window is always used.
   assign bright_s = 4'hF;
`endif

   // On-window compare: past the dead time and within the brightness share.
   always_comb begin
      cnt_ext_s = 32'(cnt_r);
      on_len_s  = (WIN_LEN * (32'(bright_s) + 32'd1)) >> 4;
      if (cnt_ext_s >= BLANK_CYCLES) begin
         on_s = ((cnt_ext_s - BLANK_CYCLES) < on_len_s);
      end else begin
         on_s = 1'b0;
      end
   end

   assign nibble_s = shadow_digit_r[{idx_r, 2'b00} +: 4];

   seven_seg_decoder u_decoder (
      .nibble (nibble_s),
      .seg    (glyph_s)
   );

   // Next output values: the current digit inside the on-window, all-off outside.
   // A blank nibble still selects its anode; its segments are simply all off.
   always_comb begin
      an_s  = AN_OFF;
      seg_s = SEG_BLANK;
      dp_s  = 1'b1;
      if (on_s) begin
         an_s  = ~(8'h01 << idx_r);
         seg_s = glyph_s;
         dp_s  = ~shadow_dot_r[idx_r];
      end else begin
         an_s  = AN_OFF;
         seg_s = SEG_BLANK;
         dp_s  = 1'b1;
      end
   end

   // Output registers: one cycle behind the slot state, glitch-free pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= AN_OFF;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else begin
         an  <= an_s;
         seg <= seg_s;
         dp  <= dp_s;
      end
   end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Scoreboard bench for seven_segment_scan_driver (SCAN_DIV=16, BLANK_CYCLES=2).
// The reference model works from elapsed cycles since reset release: slot and
// digit position come from division, the shown word from the last frame snapshot.
module tb_seven_segment_scan_driver;

   localparam int SD    = 16;
   localparam int BL    = 2;
   localparam int FRAME = 8 * SD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] digit;
   logic [7:0]  en_dot;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
`ifdef BRIGHTNESS_EN
   logic [3:0]  brightness;
`endif

   always #5 clk = ~clk;

   seven_segment_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
      .clk        (clk),
      .rst        (rst),
      .digit      (digit),
      .en_dot     (en_dot),
`ifdef BRIGHTNESS_EN
      .brightness (brightness),
`endif
      .an         (an),
      .seg        (seg),
      .dp         (dp)
   );

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   exp_t        sb_q[$];
   int          total = 0;
   int          bad   = 0;
   int          n;          // posedges since reset release
   logic [31:0] m_digit;
   logic [7:0]  m_dot;
   int          m_b;
   logic [6:0]  glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F};

   function automatic int cur_b();
`ifdef BRIGHTNESS_EN
      return int'(brightness);
`else
      return 15;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      n       = 0;
      m_digit = 32'hFFFF_FFFF;
      m_dot   = 8'h00;
      m_b     = 15;
      sb_q.delete();
   endtask

   // Expected outputs after the next posedge (they reflect the cycle before it).
   task automatic push_expected();
      int   j, c, i, lit_len;
      exp_t e;
      n++;
      j       = n - 1;
      c       = j % SD;
      i       = (j / SD) % 8;
      lit_len = ((SD - BL) * (m_b + 1)) / 16;
      if (c >= BL && (c - BL) < lit_len) begin
         e.an  = 8'(255 - (1 << i));
         e.seg = glyph_tab[(m_digit >> (4 * i)) & 32'hF];
         e.dp  = m_dot[i] ? 1'b0 : 1'b1;
      end else begin
         e.an  = 8'hFF;
         e.seg = 7'h7F;
         e.dp  = 1'b1;
      end
      sb_q.push_back(e);
      if (n % FRAME == 0) begin
         m_digit = digit;
         m_dot   = en_dot;
         m_b     = cur_b();
      end
   endtask

   task automatic tick();
      @(negedge clk);
      push_expected();
      @(posedge clk);
      #2;
   endtask

   task automatic run(input int k);
      repeat (k) tick();
   endtask

   task automatic run_to(input int r);
      do tick(); while (n % FRAME != r);
   endtask

   task automatic rand_inputs();
      digit  = $urandom();
      en_dot = 8'($urandom());
`ifdef BRIGHTNESS_EN
      brightness = 4'($urandom_range(0, 15));
`endif
   endtask

   // Monitor: every active cycle the DUT presents outputs; pop and compare.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (!rst) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow at t=%0t: no expected entry", $time);
         end else begin
            e = sb_q.pop_front();
            check("an",  32'(an),  32'(e.an));
            check("seg", 32'(seg), 32'(e.seg));
            check("dp",  32'(dp),  32'(e.dp));
         end
      end
   end

   initial begin
      digit  = 32'h7654_3210;
      en_dot = 8'h00;
`ifdef BRIGHTNESS_EN
      brightness = 4'hF;
`endif
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      check("reset_an",  32'(an),  32'h0000_00FF);
      check("reset_seg", 32'(seg), 32'h0000_007F);
      check("reset_dp",  32'(dp),  32'h0000_0001);
      rst = 1'b0;

      // Blank first frame, then 7654_3210 scanning.
      run(3 * FRAME);

      // Mid-frame change must wait for the frame wrap.
      digit = 32'h0000_0000;
      run_to(0);
      run_to(3 * SD);
      digit = 32'h8888_8888;
      run(2 * FRAME);

      // Blank digits with dots on positions 0 and 7.
      digit  = 32'hFFFF_FFFF;
      en_dot = 8'h81;
      run(3 * FRAME);

`ifdef BRIGHTNESS_EN
      digit      = 32'hEDCB_A987;
      brightness = 4'h3;
      run(2 * FRAME);
      brightness = 4'hF;
      run(2 * FRAME);
`endif

      // Asynchronous reset in the middle of slot 5 (cnt=9).
      digit  = 32'h1234_5678;
      en_dot = 8'h20;
      run(2 * FRAME);
      run_to(5 * SD + 9);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_an",  32'(an),  32'h0000_00FF);
      check("async_rst_seg", 32'(seg), 32'h0000_007F);
      check("async_rst_dp",  32'(dp),  32'h0000_0001);
      repeat (2) @(posedge clk);
      #2;
      model_reset();
      rst = 1'b0;
      run(2 * FRAME);

      // Random traffic with inputs changing at arbitrary points of the frame.
      repeat (12 * FRAME) begin
         if ($urandom_range(0, 19) == 0) rand_inputs();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
